// File: rtl/sram_burst_master.sv
// Burst command to single-beat SRAM request initiator with data streaming.
// Optional per-beat watchdog abort: define SRAM_MASTER_TIMEOUT_EN.
module sram_burst_master #(
    parameter int DATA_WIDTH     = 128,
    parameter int MAX_ADDR       = 128,
    parameter int ADDR_BIT_WIDTH = $clog2(MAX_ADDR),
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [ADDR_BIT_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]      i_cmd_len,
    input  logic                      i_wdata_valid,
    output logic                      o_wdata_ready,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    output logic                      o_rdata_valid,
    output logic [DATA_WIDTH-1:0]     o_rdata,
    output logic                      o_cmd_done,
    output logic                      o_cmd_err,
    output logic                      o_read_req,
    output logic                      o_write_req,
    output logic [ADDR_BIT_WIDTH-1:0] o_read_addr,
    output logic [ADDR_BIT_WIDTH-1:0] o_write_addr,
    output logic [DATA_WIDTH-1:0]     o_wdata,
    input  logic [DATA_WIDTH-1:0]     i_rdata,
    input  logic                      i_r_trans_done,
    input  logic                      i_w_trans_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    localparam int CW = LEN_WIDTH + 1;
    localparam logic [ADDR_BIT_WIDTH-1:0] LAST_ADDR = ADDR_BIT_WIDTH'(MAX_ADDR - 1);

    state_e                    state_q, state_d;
    logic                      write_q, write_d;
    logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      beat_done;
    logic                      timeout;

    assign beat_done    = write_q ? i_w_trans_done : i_r_trans_done;
    assign o_read_addr  = addr_q;
    assign o_write_addr = addr_q;

`ifdef SRAM_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    // Counter is zero on the first WAIT cycle of every beat.
    always_comb begin
        tmo_d = '0;
        if (state_q == WAIT) tmo_d = tmo_q + 1'b1;
        err_d = err_q;
        if (state_q == WAIT) err_d = timeout && !beat_done;
    end

    assign timeout   = (state_q == WAIT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign o_cmd_err = (state_q == DONE) && err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
    assign timeout   = 1'b0;
    assign o_cmd_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        wdata_d       = wdata_q;
        o_cmd_ready   = 1'b0;
        o_wdata_ready = 1'b0;
        o_read_req    = 1'b0;
        o_write_req   = 1'b0;
        o_rdata_valid = 1'b0;
        o_rdata       = '0;
        o_cmd_done    = 1'b0;
        o_wdata       = wdata_q;
        unique case (state_q)
            IDLE: begin
                o_cmd_ready = i_rst_n;
                if (i_cmd_valid) begin
                    write_d = i_cmd_write;
                    addr_d  = i_cmd_addr;
                    cnt_d   = {1'b0, i_cmd_len} + CW'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (write_q) begin
                    // Beat data is forwarded in the request cycle, then held from wdata_q.
                    if (i_wdata_valid) begin
                        o_wdata_ready = 1'b1;
                        o_write_req   = 1'b1;
                        o_wdata       = i_wdata;
                        wdata_d       = i_wdata;
                        state_d       = WAIT;
                    end
                end else begin
                    o_read_req = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (beat_done) begin
                    if (!write_q) begin
                        o_rdata_valid = 1'b1;
                        o_rdata       = i_rdata;
                    end
                    cnt_d   = cnt_q - CW'(1);
                    addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    state_d = (cnt_q == CW'(1)) ? DONE : ISSUE;
                end else if (timeout) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_cmd_done = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
        end
    end
endmodule
